io_stall_seq: RTL and testbench

- Sequencer for the processor's stall and I/O handshake.
- Watches the control unit's stop/in/out outputs and freezes the PC while an I/O instruction waits for the operator.
- Debounces the confirm push-button and returns a one-cycle `sinal` pulse to the control unit so the in/out instruction completes.
- Also latches halt until reset.

---
 rtl/io_stall_seq.sv | 207 ++++++++++++++++++++
 tb/tb_io_stall_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/io_stall_seq.sv
// rtl/io_stall_seq.sv - stall and I/O handshake sequencer for the processor control unit
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   stop         control unit stop request
//   in           control unit "in" instruction flag
//   out          control unit "out" instruction flag
//   confirma     raw confirm push-button, active-high, asynchronous to clock
//   sinal        one-cycle completion pulse back to the control unit
//   habilita_pc  PC write enable
//   captura_out  one-cycle strobe to latch the display register
//   esperando    high while waiting for the operator
//   parado       high after halt, sticky until reset
//   timeout      sticky auto-release flag (constant 0 unless IO_TIMEOUT_EN is defined)
//
// Optional build macro: IO_TIMEOUT_EN adds an auto-release timer in ESPERA_APERTO.

module io_stall_seq #(
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int TIMEOUT_CICLOS  = 1000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic stop,
  input  logic in,
  input  logic out,
  input  logic confirma,
  output logic sinal,
  output logic habilita_pc,
  output logic captura_out,
  output logic esperando,
  output logic parado,
  output logic timeout
);

  if (DEBOUNCE_CICLOS < 2 || TIMEOUT_CICLOS < 2) begin : g_param_check
    $error("io_stall_seq: DEBOUNCE_CICLOS and TIMEOUT_CICLOS must be >= 2");
  end

  localparam int DW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    ESPERA_APERTO,
    DEB_APERTO,
    ESPERA_SOLTA,
    DEB_SOLTA,
    LIBERA,
    PARADO
  } estado_t;

  estado_t estado, prox_estado;

  logic sync1, conf_s;
  logic guarda;
  logic [DW-1:0] deb_cnt;
  logic deb_ativo, deb_casa, deb_fim;
  logic stop_ef;
  logic to_fim;

  // Two-flop synchronizer; only conf_s is used downstream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      conf_s <= 1'b0;
    end else begin
      sync1  <= confirma;
      conf_s <= sync1;
    end
  end

  // DEB_APERTO waits for a stable 1, DEB_SOLTA for a stable 0.
  assign deb_ativo = (estado == DEB_APERTO) || (estado == DEB_SOLTA);
  assign deb_casa  = (conf_s == (estado == DEB_APERTO));
  assign deb_fim   = deb_ativo && deb_casa && (deb_cnt == DEB_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt <= '0;
    end else if (!deb_ativo || !deb_casa || deb_fim) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_MAX) begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // The cycle after LIBERA the control unit may still show stop for the
  // instruction that just completed; masking it avoids re-entering the wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      guarda <= 1'b0;
    end else begin
      guarda <= (estado == LIBERA);
    end
  end

  assign stop_ef = stop & ~guarda;

`ifdef IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] to_cnt;
  logic          timeout_q;

  assign to_fim = (estado == ESPERA_APERTO) && (to_cnt == TO_MAX);

  // Runs only while idling in ESPERA_APERTO; any exit (press or timeout) clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (estado != ESPERA_APERTO) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if (to_fim) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_fim  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    sinal       = 1'b0;
    habilita_pc = 1'b0;
    captura_out = 1'b0;
    esperando   = 1'b0;
    parado      = 1'b0;
    case (estado)
      OCIOSO: begin
        habilita_pc = ~stop_ef;
        if (stop_ef) begin
          if (in || out) begin
            prox_estado = ESPERA_APERTO;
            // in and out together behave as in: no display capture.
            captura_out = out & ~in;
          end else begin
            prox_estado = PARADO;
          end
        end
      end
      ESPERA_APERTO: begin
        esperando = 1'b1;
        if (to_fim) begin
          prox_estado = LIBERA;
        end else if (conf_s) begin
          prox_estado = DEB_APERTO;
        end
      end
      DEB_APERTO: begin
        esperando = 1'b1;
        if (!deb_casa) begin
          prox_estado = ESPERA_APERTO;
        end else if (deb_fim) begin
          prox_estado = ESPERA_SOLTA;
        end
      end
      ESPERA_SOLTA: begin
        esperando = 1'b1;
        if (!conf_s) begin
          prox_estado = DEB_SOLTA;
        end
      end
      DEB_SOLTA: begin
        esperando = 1'b1;
        if (!deb_casa) begin
          prox_estado = ESPERA_SOLTA;
        end else if (deb_fim) begin
          prox_estado = LIBERA;
        end
      end
      LIBERA: begin
        sinal       = 1'b1;
        habilita_pc = 1'b1;
        prox_estado = OCIOSO;
      end
      PARADO: begin
        parado = 1'b1;
      end
      default: begin
        prox_estado = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_io_stall_seq.sv
// tb/tb_io_stall_seq.sv - directed vector bench for io_stall_seq

module tb_io_stall_seq;

  logic clock;
  logic reset_n;
  logic stop, in, out, confirma;
  logic sinal, habilita_pc, captura_out, esperando, parado, timeout;

  int n_vec;
  int n_err;

  io_stall_seq #(
    .DEBOUNCE_CICLOS(4),
    .TIMEOUT_CICLOS (20)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stop       (stop),
    .in         (in),
    .out        (out),
    .confirma   (confirma),
    .sinal      (sinal),
    .habilita_pc(habilita_pc),
    .captura_out(captura_out),
    .esperando  (esperando),
    .parado     (parado),
    .timeout    (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // stim = {stop,in,out,confirma}; exp = {sinal,habilita_pc,captura_out,esperando,parado}
  typedef struct {
    string      name;
    logic [3:0] stim;
    logic [4:0] exp;
  } vec_t;

  vec_t tab[$];

  logic [4:0] obs;
  assign obs = {sinal, habilita_pc, captura_out, esperando, parado};

  task automatic add(input string n, input int reps, input logic [3:0] s, input logic [4:0] e);
    vec_t v;
    for (int k = 0; k < reps; k++) begin
      v.name = n;
      v.stim = s;
      v.exp  = e;
      tab.push_back(v);
    end
  endtask

  task automatic check(input string n, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (sinal,hab,cap,esp,par)", n, act, exp);
    end
  endtask

  task automatic check1(input string n, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic [3:0] s);
    {stop, in, out, confirma} = s;
  endtask

  task automatic run_table();
    for (int i = 0; i < tab.size(); i++) begin
      apply(tab[i].stim);
      @(negedge clock);
      check($sformatf("%s[%0d]", tab[i].name, i), obs, tab[i].exp);
      next_cycle();
    end
    tab.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    apply(4'b0000);
    @(negedge clock);
    check("reset_state", obs, 5'b01000);
    check1("reset_timeout", timeout, 1'b0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    apply(4'b0000);
    #1;
    do_reset();

    // out instruction, bouncing button, then a clean press and release, guard cycle
    add("out_entry",    1, 4'b1010, 5'b00100);
    add("out_bounce1",  1, 4'b1011, 5'b00010);
    add("out_bounce0",  1, 4'b1010, 5'b00010);
    add("out_bounce1b", 1, 4'b1011, 5'b00010);
    add("out_settle",   4, 4'b1010, 5'b00010);
    add("out_press",    9, 4'b1011, 5'b00010);
    add("out_release",  7, 4'b1010, 5'b00010);
    add("out_sinal",    1, 4'b1010, 5'b11000);
    add("out_guard",    1, 4'b1010, 5'b01000);
    add("out_idle",     2, 4'b0000, 5'b01000);
    run_table();

    // in instruction: 10 cycles pressed, release, single sinal one cycle after acceptance
    add("in_entry",   1, 4'b1100, 5'b00000);
    add("in_press",  10, 4'b1101, 5'b00010);
    add("in_release", 7, 4'b1100, 5'b00010);
    add("in_sinal",   1, 4'b1100, 5'b11000);
    add("in_idle",    2, 4'b0000, 5'b01000);
    run_table();

    // in and out together behave as in; then reset lands mid DEB_SOLTA
    apply(4'b1110);
    @(negedge clock);
    check("inout_no_capture", obs, 5'b00000);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      apply(4'b1111);
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      apply(4'b1110);
      next_cycle();
    end
    @(negedge clock);
    check("mid_deb_solta", obs, 5'b00010);
    #1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      check1("post_reset_no_sinal", sinal, 1'b0);
      next_cycle();
    end

    // halt: sticky regardless of the button
    apply(4'b1000);
    @(negedge clock);
    check("halt_entry", obs, 5'b00000);
    next_cycle();
    for (int i = 0; i < 100; i++) begin
      apply({1'b1, 2'b00, 1'($urandom_range(0, 1))});
      @(negedge clock);
      check("halt_hold", obs, 5'b00001);
      next_cycle();
    end
    do_reset();
    @(negedge clock);
    check("halt_cleared", obs, 5'b01000);
    next_cycle();

    // no press: auto-release only with the timeout feature
    apply(4'b1100);
    next_cycle();
`ifdef IO_TIMEOUT_EN
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("to_wait", obs, 5'b00010);
      check1("to_flag_low", timeout, 1'b0);
      next_cycle();
    end
    @(negedge clock);
    check("to_sinal", obs, 5'b11000);
    check1("to_flag_set", timeout, 1'b1);
    next_cycle();
    apply(4'b0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check1("to_flag_sticky", timeout, 1'b1);
      next_cycle();
    end
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      check("no_timeout_wait", obs, 5'b00010);
      check1("no_timeout_flag", timeout, 1'b0);
      next_cycle();
    end
`endif
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
